// File: rtl/register_file_pkg.sv
// Shared constants for the RV32I integer register file.
// Parameter defaults in the register file derive from these values.
package register_file_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

endpackage

// File: rtl/register_file_read_port.sv
// One combinational read port: x0 forced to zero, Writeback-to-Decode bypass,
// and a zero result for every address while reset is asserted.
module register_file_read_port
    import register_file_pkg::*;
#(
    parameter int DATA_W = XLEN,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int NREGS  = 2 ** ADDR_W
) (
    input  logic                          rst,
    input  logic [ADDR_W-1:0]             addr,
    input  logic [NREGS-1:0][DATA_W-1:0]  regs,
    input  logic                          we,
    input  logic [ADDR_W-1:0]             waddr,
    input  logic [DATA_W-1:0]             wdata,
    output logic [DATA_W-1:0]             data
);

    // addr != 0 already guarantees the bypass never fires for a write to x0.
    always_comb begin
        data = '0;
        if (rst && (addr != '0)) begin
            if (we && (waddr == addr)) begin
                data = wdata;
            end else begin
                data = regs[addr];
            end
        end
    end

endmodule

// File: rtl/register_file.sv
// RV32I integer register file: 31 stored registers (x0 hardwired to zero),
// two combinational read ports with same-cycle write bypass, one write port.
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_W = XLEN,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteW,
    input  logic [ADDR_W-1:0] RdW,
    input  logic [DATA_W-1:0] ResultW,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]            regs_q [1:NREGS-1];
    logic [NREGS-1:0][DATA_W-1:0] regs_view;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (RegWriteW && (RdW != '0)) begin
            regs_q[RdW] <= ResultW;
        end
    end

    // Slot 0 has no storage; present it as constant zero to the read ports.
    always_comb begin
        regs_view = '0;
        for (int i = 1; i < NREGS; i++) begin
            regs_view[i] = regs_q[i];
        end
    end

    register_file_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_port1 (
        .rst   (rst),
        .addr  (A1),
        .regs  (regs_view),
        .we    (RegWriteW),
        .waddr (RdW),
        .wdata (ResultW),
        .data  (RD1)
    );

    register_file_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_port2 (
        .rst   (rst),
        .addr  (A2),
        .regs  (regs_view),
        .we    (RegWriteW),
        .waddr (RdW),
        .wdata (ResultW),
        .data  (RD2)
    );

endmodule

// File: tb/tb_register_file.sv
// Randomized self-checking bench for register_file against an array-based
// model of the architectural register state plus the bypass read rule.
module tb_register_file;

    localparam int W  = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst;
    logic          RegWriteW;
    logic [AW-1:0] RdW;
    logic [W-1:0]  ResultW;
    logic [AW-1:0] A1;
    logic [AW-1:0] A2;
    logic [W-1:0]  RD1;
    logic [W-1:0]  RD2;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] model [32];
    logic [W-1:0] exp_q [$];

    register_file #(.DATA_W(W), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .RegWriteW (RegWriteW),
        .RdW       (RdW),
        .ResultW   (ResultW),
        .A1        (A1),
        .A2        (A2),
        .RD1       (RD1),
        .RD2       (RD2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Architectural read: reset gives 0, x0 gives 0, a pending write wins.
    function automatic logic [W-1:0] ref_read(input logic [AW-1:0] a);
        if (!rst || a == 0) return '0;
        if (RegWriteW && RdW == a) return ResultW;
        return model[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = '0;
    endtask

    // Check both ports mid-cycle, take one rising edge, return at the falling edge.
    task automatic step(input string tag);
        #1;
        check({tag, "_rd1"}, RD1, ref_read(A1));
        check({tag, "_rd2"}, RD2, ref_read(A2));
        @(posedge clk);
        if (!rst) clear_model();
        else if (RegWriteW && RdW != 0) model[RdW] = ResultW;
        @(negedge clk);
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] rd, input logic [W-1:0] wd,
                         input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        RegWriteW = we;
        RdW       = rd;
        ResultW   = wd;
        A1        = a1;
        A2        = a2;
    endtask

    initial begin
        rst = 1'b0;
        clear_model();
        drive(1'b0, 5'd0, '0, 5'd2, 5'd3);
        @(negedge clk);

        // reset held: reads are zero, bypass disabled, writes ignored
        #1;
        check("rst_rd1", RD1, 32'd0);
        check("rst_rd2", RD2, 32'd0);
        drive(1'b1, 5'd2, 32'h1111_2222, 5'd2, 5'd3);
        #1;
        check("rst_nobypass", RD1, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 5'd0, '0, 5'd2, 5'd3);
        #1;
        check("rst_nowrite", RD1, 32'd0);

        // basic writes
        drive(1'b1, 5'd2, 32'd13, 5'd2, 5'd3);
        step("wr2");
        drive(1'b1, 5'd3, 32'd10, 5'd2, 5'd3);
        step("wr3");
        drive(1'b0, 5'd0, '0, 5'd2, 5'd3);
        #1;
        check("basic_rd1", RD1, 32'd13);
        check("basic_rd2", RD2, 32'd10);

        // x0 write discarded, no bypass
        drive(1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0);
        #1;
        check("x0_during", RD1, 32'd0);
        step("x0_wr");
        drive(1'b0, 5'd0, '0, 5'd0, 5'd2);
        #1;
        check("x0_after", RD1, 32'd0);

        // bypass, and the value persists after the edge
        drive(1'b1, 5'd5, 32'h1234, 5'd5, 5'd3);
        #1;
        check("byp_before", RD1, 32'h1234);
        check("byp_other", RD2, 32'd10);
        step("byp");
        drive(1'b0, 5'd5, 32'hFFFF, 5'd5, 5'd5);
        #1;
        check("byp_after", RD1, 32'h1234);

        // enable low holds stored value
        drive(1'b1, 5'd7, 32'h55, 5'd0, 5'd7);
        step("wr7");
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 5'd7, 32'hAA, 5'd0, 5'd7);
            step("en_low");
        end
        #1;
        check("en_low_x7", RD2, 32'h55);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [AW-1:0] rd;
            rd = AW'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 1)), rd, $urandom(),
                  ($urandom_range(0, 3) == 0) ? rd : AW'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) == 0) ? rd : AW'($urandom_range(0, 31)));
            step("rand");
        end

        // async reset mid-cycle clears everything before the next edge
        drive(1'b0, 5'd0, '0, 5'd2, 5'd5);
        #2;
        rst = 1'b0;
        clear_model();
        #1;
        check("async_rd1", RD1, 32'd0);
        check("async_rd2", RD2, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_held_rd1", RD1, 32'd0);

        // reset during a write cycle: the write is lost
        drive(1'b1, 5'd9, 32'hCAFE_F00D, 5'd0, 5'd0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 5'd0, '0, 5'd9, 5'd9);
        #1;
        check("rst_mid_write", RD1, 32'd0);

        // sweep: x_i = i*3, then all port pairs including A1 == A2
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, AW'(i), W'(i * 3), AW'(i), 5'd0);
            step("sweep_wr");
        end
        RegWriteW = 1'b0;
        for (int a = 0; a < 32; a++) begin
            for (int b = 0; b < 32; b++) begin
                A1 = AW'(a);
                A2 = AW'(b);
                exp_q.push_back(W'(a * 3));
                exp_q.push_back(W'(b * 3));
                #1;
                check("sweep_rd1", RD1, exp_q.pop_front());
                check("sweep_rd2", RD2, exp_q.pop_front());
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
